// File: rtl/mem_bus_master.sv
// Bus initiator for the single-port memory: single-beat writes, incrementing read
// bursts, one-cycle read latency absorbed, and a turnaround cycle before the next access.
module mem_bus_master #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  output logic                  write_enable,
  output logic                  output_enable
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_TURN
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  prev_read_q, prev_read_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    prev_read_d = (state_q == S_READ);
    rsp_valid_d = prev_read_q;
    rsp_rdata_d = rsp_rdata_q;

    // The memory's registered output reaches the bus one cycle after each READ cycle.
    if (prev_read_q) begin
      rsp_rdata_d = data_bus;
    end

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          base_d  = req_addr;
          wdata_d = req_wdata;
          len_d   = req_len;
          beat_d  = '0;
          state_d = req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_READ: begin
        if (beat_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_TURN;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      prev_read_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      prev_read_q <= prev_read_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Outputs are forced to their idle values while reset is high, including the
  // first reset cycle before the state register has been cleared.
  assign req_ready     = (state_q == S_IDLE) && !reset;
  assign busy          = (state_q != S_IDLE) && !reset;
  assign write_enable  = (state_q == S_WRITE) && !reset;
  assign output_enable = ((state_q == S_READ) || (state_q == S_DRAIN)) && !reset;
  assign address       = reset ? '0 : base_q + ADDR_WIDTH'(beat_q);
  assign data_bus      = write_enable ? wdata_q : 'z;
  assign rsp_valid     = rsp_valid_q && !reset;
  assign rsp_rdata     = reset ? '0 : rsp_rdata_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: a memory with one-cycle registered reads
// on the shared bus, and a transaction-level model predicting every output per cycle.
module tb_mem_bus_master;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int LW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MAXC  = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [LW-1:0] req_len = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [AW-1:0] address;
  wire  [DW-1:0] data_bus;
  logic          write_enable;
  logic          output_enable;

  mem_bus_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_len      (req_len),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .address      (address),
    .data_bus     (data_bus),
    .write_enable (write_enable),
    .output_enable(output_enable)
  );

  always #5 clk = ~clk;

  // Memory block: writes commit at the edge, reads are registered and driven while OE is high.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] mem_rd_q = '0;
  always @(posedge clk) begin
    if (write_enable) mem[address] <= data_bus;
    if (output_enable) mem_rd_q <= mem[address];
  end
  assign data_bus = output_enable ? mem_rd_q : 'z;

  // Reference model: contents plus per-cycle predicted outputs.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          e_we [MAXC];
  logic          e_oe [MAXC];
  logic          e_rv [MAXC];
  logic [AW-1:0] e_addr [MAXC];
  logic [DW-1:0] e_wd [MAXC];
  logic [DW-1:0] e_rd [MAXC];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int free_at  = 0;
  logic acc    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  task automatic clear_from(input int c);
    for (int k = c; k < c + 24 && k < MAXC; k++) begin
      e_we[k] = 1'b0;
      e_oe[k] = 1'b0;
      e_rv[k] = 1'b0;
    end
  endtask

  task automatic model_accept(input int c);
    int n;
    if (req_write) begin
      e_we[c+1]   = 1'b1;
      e_addr[c+1] = req_addr;
      e_wd[c+1]   = req_wdata;
      ref_mem[req_addr] = req_wdata;
      free_at = c + 2;
    end else begin
      n = int'(req_len) + 1;
      for (int i = 0; i < n; i++) begin
        e_oe[c+1+i]   = 1'b1;
        e_addr[c+1+i] = AW'((int'(req_addr) + i) % DEPTH);
        e_rv[c+3+i]   = 1'b1;
        e_rd[c+3+i]   = ref_mem[(int'(req_addr) + i) % DEPTH];
      end
      e_oe[c+1+n]   = 1'b1;
      e_addr[c+1+n] = AW'((int'(req_addr) + n - 1) % DEPTH);
      free_at = c + n + 3;
    end
  endtask

  task automatic evaluate();
    logic idle;
    if (cyc >= MAXC - 40) begin
      $display("FAIL cycle_budget cyc=%0d got=overrun want=<%0d", cyc, MAXC - 40);
      $fatal(1);
    end
    check("we_oe_exclusive", {31'd0, write_enable & output_enable}, 32'd0);
    if (reset) begin
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check("rst_address", 32'(address), 32'd0);
      check("rst_we", {31'd0, write_enable}, 32'd0);
      check("rst_oe", {31'd0, output_enable}, 32'd0);
      clear_from(cyc + 1);
      free_at = cyc + 1;
      acc = 1'b0;
    end else begin
      idle = (cyc >= free_at);
      check("req_ready", {31'd0, req_ready}, {31'd0, idle});
      check("busy", {31'd0, busy}, {31'd0, !idle});
      check("write_enable", {31'd0, write_enable}, {31'd0, e_we[cyc]});
      check("output_enable", {31'd0, output_enable}, {31'd0, e_oe[cyc]});
      check("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv[cyc]});
      if (e_we[cyc] || e_oe[cyc]) check("address", 32'(address), 32'(e_addr[cyc]));
      if (e_we[cyc]) check("write_data_bus", 32'(data_bus), 32'(e_wd[cyc]));
      if (e_rv[cyc]) check("rsp_rdata", 32'(rsp_rdata), 32'(e_rd[cyc]));
      acc = idle && req_valid;
      if (acc) model_accept(cyc);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_n(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [LW-1:0] l);
    int budget = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_len   = l;
    do begin
      cycle();
      budget++;
    end while (!acc && budget < 40);
    if (!acc) check("accept_timeout", 32'(budget), 32'd0);
    req_valid = 1'b0;
    req_wdata = DW'($urandom);
    req_len   = LW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int k = 0; k < MAXC; k++) begin
      e_we[k] = 1'b0;
      e_oe[k] = 1'b0;
      e_rv[k] = 1'b0;
      e_addr[k] = '0;
      e_wd[k] = '0;
      e_rd[k] = '0;
    end
    @(posedge clk);
    #1;
    do_reset(3);
    idle_n(2);

    // Single write then single-beat read.
    issue(1'b1, 11'd5, 16'hBEEF, 4'd0);
    idle_n(1);
    issue(1'b0, 11'd5, 16'h0000, 4'd0);
    idle_n(4);

    // Sixteen back-to-back writes then a full-length burst.
    for (int i = 0; i < 16; i++) issue(1'b1, AW'(100 + i), DW'(16'h1000 + i), 4'd0);
    issue(1'b0, 11'd100, 16'h0000, 4'd15);
    idle_n(20);

    // Burst wrapping past the top of the address space.
    issue(1'b1, 11'd2046, 16'h00A0, 4'd0);
    issue(1'b1, 11'd2047, 16'h00A1, 4'd0);
    issue(1'b1, 11'd0, 16'h00A2, 4'd0);
    issue(1'b1, 11'd1, 16'h00A3, 4'd0);
    issue(1'b0, 11'd2046, 16'h0000, 4'd3);
    idle_n(6);

    // Read with a write pending behind it.
    issue(1'b0, 11'd7, 16'h0000, 4'd0);
    issue(1'b1, 11'd7, 16'h5A5A, 4'd0);
    issue(1'b0, 11'd7, 16'h0000, 4'd0);
    idle_n(5);

    // Reset during the third beat of an eight-beat read.
    issue(1'b0, 11'd0, 16'h0000, 4'd7);
    idle_n(2);
    do_reset(2);
    issue(1'b0, 11'd0, 16'h0000, 4'd0);
    idle_n(5);

    // Randomised traffic with occasional resets during reads.
    for (int t = 0; t < 120; t++) begin
      logic w;
      w = ($urandom_range(0, 1) == 1);
      issue(w, AW'($urandom), DW'($urandom), LW'($urandom));
      if (!w && $urandom_range(0, 19) == 0) begin
        idle_n($urandom_range(0, 4));
        do_reset($urandom_range(1, 2));
      end
      idle_n($urandom_range(0, 2));
    end
    idle_n(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Bus initiator that drives the single-port `memory` block's `address`, `data_bus`, `write_enable` and `output_enable` pins from a valid/ready request interface. It issues single-beat writes and incrementing read bursts, and absorbs the memory's one-cycle registered read latency. It returns read data on a response strobe and enforces a bus-turnaround cycle so the master and the memory never drive `data_bus` at the same time. It sits between the core's load/store path and `memory`.

## Interface
- ADDR_WIDTH, 11, memory address width; depth is 2**ADDR_WIDTH words
- DATA_WIDTH, 16, word width
- LEN_WIDTH, 4, burst length field width; beats = req_len + 1
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready at a rising edge
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  start address
- req_wdata  input  DATA_WIDTH  write data (writes only)
- req_len  input  LEN_WIDTH  read beats minus one; ignored for writes
- rsp_valid  output  1  one-cycle strobe per read beat; no backpressure
- rsp_rdata  output  DATA_WIDTH  read data, valid when rsp_valid = 1
- busy  output  1  high in every state except IDLE
- address  output  ADDR_WIDTH  to memory address
- data_bus  inout  DATA_WIDTH  shared with memory; driven only in WRITE, otherwise Z
- write_enable  output  1  to memory
- output_enable  output  1  to memory

## Operation
- States: IDLE, WRITE, READ, DRAIN, TURN.
- IDLE: req_ready=1, write_enable=0, output_enable=0, data_bus=Z.
  - On accept, latch addr, wdata and len.
  - Go to WRITE if req_write=1, otherwise go to READ with beat counter = 0.
- WRITE (1 cycle): write_enable=1, output_enable=0, address=latched addr, data_bus=latched wdata. The memory commits the word at the end of this cycle. Next state is IDLE.
- READ (len+1 cycles): output_enable=1, write_enable=0, address=base+beat. The counter increments each cycle. After the beat where counter == len, go to DRAIN.
- Address arithmetic is modulo 2**ADDR_WIDTH: a burst from 2046 with len=3 reads 2046, 2047, 0, 1.
- DRAIN (1 cycle): output_enable stays 1 and address holds the last value so the memory presents the final word. Next state is TURN.
- TURN (1 cycle): output_enable=0, data_bus=Z, req_ready=0. Next state is IDLE.
- Capture: data_bus is registered into rsp_rdata at the end of each cycle whose predecessor was a READ cycle. rsp_valid is high in the following cycle.
- Invariants:
  - write_enable and output_enable are never both 1.
  - data_bus is never driven while output_enable=1.
  - req_ready is 1 only in IDLE.
- Reset (any state, including mid-burst): the next state is IDLE. Every in-flight beat is dropped and no further rsp_valid is raised.

## Timing
- Reset values, held while reset=1: req_ready=0, busy=0, rsp_valid=0, rsp_rdata=0, address=0, write_enable=0, output_enable=0, data_bus=Z. From the first cycle after reset deasserts: req_ready=1, busy=0.
- Cycle numbering: the accept edge closes cycle 0.
- Write:
  - WRITE in cycle 1; back in IDLE with req_ready=1 in cycle 2.
  - Maximum write rate is one write per 2 cycles.
- Read of N = len+1 beats:
  - Addresses are presented in cycles 1..N, DRAIN in cycle N+1, TURN in cycle N+2, IDLE in cycle N+3.
  - Beat i (0-based) is presented in cycle 1+i and appears on the bus in cycle 2+i. rsp_valid is high in cycle 3+i.
  - Accept-to-first-response latency is 3 cycles. Responses are contiguous, one per cycle, in address order.
  - The last rsp_valid lands in cycle N+2, i.e. during TURN.
- A request held on req_valid while busy=1 is not accepted, and its fields must stay stable until accepted.

## Test plan
- Reset: assert reset for 2 cycles mid-stream -> all outputs hold the reset values above; req_ready=1 and busy=0 on the first cycle after release.
- Single write then read: write 0xBEEF to address 5, then read address 5 with len=0 -> write_enable=1 for exactly 1 cycle; rsp_valid for 1 cycle with rsp_rdata=0xBEEF, 3 cycles after the read accept.
- Burst read: write 0x1000+i to addresses 100..115 (16 writes, one per 2 cycles), then read from 100 with len=15 -> 16 consecutive rsp_valid cycles carrying 0x1000..0x100F; TURN then IDLE.
- Wrap-around: write 0xA0, 0xA1, 0xA2, 0xA3 to addresses 2046, 2047, 0, 1; read from 2046 with len=3 -> rsp_rdata sequence 0xA0, 0xA1, 0xA2, 0xA3 and address sequence 2046, 2047, 0, 1.
- Back-to-back and contention: read (len=0) immediately followed by a pending write -> write accepted only in the IDLE cycle after TURN; a checker sees no cycle with output_enable=1 while data_bus is driven by the master, and never write_enable & output_enable.
- Reset mid-burst: assert reset during the third beat of a len=7 read -> at most the responses already due before the reset edge appear; none after; next read of address 0 returns correct data.
